irq_coalescer: RTL and testbench

- Upstream interrupt-aggregation stage that feeds the MSI generator.
- Collects per-source event pulses from the datapath (FC ports, DMA rings, etc.).
- Applies per-source count/timeout coalescing, sticky W1C status and enable masks.
- Drives level `irq[N_SRC-1:0]` into the MSI block, which fires one MSI per `irq` rising edge. This block therefore guarantees every new interrupt is a fresh 0->1 transition.
- Configured by the host over a small Avalon-MM CSR slave.

---
 rtl/irq_coalescer.sv | 169 ++++++++++++++++
 tb/tb_irq_coalescer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_coalescer.sv
// irq_coalescer: per-source event coalescing (count threshold and holdoff
// timeout) with sticky W1C status, enable mask and an Avalon-MM CSR slave.
//
// Ports:
//   clk           block clock (same domain as the MSI stage)
//   reset_n       asynchronous active-low reset
//   event_in      per-source event strobes, one event per high cycle
//   csr_address   CSR word address
//   csr_read      read strobe; csr_readdata is valid on the next cycle
//   csr_write     write strobe
//   csr_writedata write data
//   csr_readdata  registered read data
//   irq           registered level interrupts (STATUS & MASK)
module irq_coalescer #(
    parameter int N_SRC = 8,
    parameter int CNT_W = 8,
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] event_in,
    input  logic [2:0]       csr_address,
    input  logic             csr_read,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    output logic [31:0]      csr_readdata,
    output logic [N_SRC-1:0] irq
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_FORCE   = 3'd2;
    localparam logic [2:0] A_THRESH  = 3'd3;
    localparam logic [2:0] A_TIMEOUT = 3'd4;
    localparam logic [2:0] A_COUNT   = 3'd5;

    // Number of 8-bit counter fields that fit in the COUNT word.
    localparam int NCNT = (N_SRC < 4) ? N_SRC : 4;

    logic [N_SRC-1:0] status;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] defer;
    logic [CNT_W-1:0] thresh;
    logic [TMR_W-1:0] timeout;
    logic [CNT_W-1:0] cnt [N_SRC];
    logic [TMR_W-1:0] tmr [N_SRC];

    logic [CNT_W-1:0] cnt_nx [N_SRC];
    logic [CNT_W-1:0] cnt_d  [N_SRC];
    logic [TMR_W-1:0] tmr_d  [N_SRC];
    logic [N_SRC-1:0] expire;
    logic [N_SRC-1:0] fire;
    logic [N_SRC-1:0] set_req;
    logic [N_SRC-1:0] clr_req;
    logic [N_SRC-1:0] status_d;
    logic [N_SRC-1:0] defer_d;
    logic [CNT_W-1:0] thr_eff;
    logic [31:0]      rd_mux;
    logic [31:0]      count_word;

    logic wr_status;
    logic wr_mask;
    logic wr_force;
    logic wr_thresh;
    logic wr_timeout;

    // Upper write-data bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^csr_writedata;

    assign wr_status  = csr_write && (csr_address == A_STATUS);
    assign wr_mask    = csr_write && (csr_address == A_MASK);
    assign wr_force   = csr_write && (csr_address == A_FORCE);
    assign wr_thresh  = csr_write && (csr_address == A_THRESH);
    assign wr_timeout = csr_write && (csr_address == A_TIMEOUT);

    // A threshold of zero behaves exactly like one.
    assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_nx[i] = cnt[i];
            if (event_in[i] && (cnt[i] != '1)) begin
                cnt_nx[i] = cnt[i] + CNT_W'(1);
            end
            // Timer is at 1 and about to hit 0 while events are pending.
            expire[i] = (cnt[i] != '0) && (tmr[i] == TMR_W'(1))
                        && (timeout != '0);
            fire[i] = (cnt_nx[i] >= thr_eff) || expire[i];

            cnt_d[i] = fire[i] ? '0 : cnt_nx[i];
            tmr_d[i] = tmr[i];
            if (fire[i]) begin
                tmr_d[i] = '0;
            end else if (event_in[i] && (cnt[i] == '0)
                         && (timeout != '0)) begin
                tmr_d[i] = timeout;
            end else if ((cnt[i] != '0) && (tmr[i] != '0)) begin
                tmr_d[i] = tmr[i] - TMR_W'(1);
            end
        end
    end

    // A clear in the same cycle as a set wins; the set is parked in
    // defer and lands a cycle later so irq always shows a fresh edge.
    always_comb begin
        set_req = fire | defer;
        if (wr_force) begin
            set_req = set_req | csr_writedata[N_SRC-1:0];
        end
        clr_req = wr_status ? csr_writedata[N_SRC-1:0] : '0;
        status_d = (status | set_req) & ~clr_req;
        defer_d  = set_req & clr_req;
    end

    always_comb begin
        count_word = '0;
        for (int i = 0; i < NCNT; i++) begin
            count_word[8*i +: 8] = 8'(cnt[i]);
        end
        rd_mux = '0;
        case (csr_address)
            A_STATUS:  rd_mux[N_SRC-1:0] = status;
            A_MASK:    rd_mux[N_SRC-1:0] = mask;
            A_THRESH:  rd_mux[CNT_W-1:0] = thresh;
            A_TIMEOUT: rd_mux[TMR_W-1:0] = timeout;
            A_COUNT:   rd_mux = count_word;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status       <= '0;
            mask         <= '0;
            defer        <= '0;
            thresh       <= CNT_W'(1);
            timeout      <= '0;
            irq          <= '0;
            csr_readdata <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt[i] <= '0;
                tmr[i] <= '0;
            end
        end else begin
            status <= status_d;
            defer  <= defer_d;
            irq    <= status & mask;
            for (int i = 0; i < N_SRC; i++) begin
                cnt[i] <= cnt_d[i];
                tmr[i] <= tmr_d[i];
            end
            if (wr_mask) begin
                mask <= csr_writedata[N_SRC-1:0];
            end
            if (wr_thresh) begin
                thresh <= csr_writedata[CNT_W-1:0];
            end
            if (wr_timeout) begin
                timeout <= csr_writedata[TMR_W-1:0];
            end
            // Read data reflects pre-write state of this cycle.
            if (csr_read) begin
                csr_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_irq_coalescer.sv
// tb_irq_coalescer: directed and random stimulus against a deadline-based
// reference model; expected responses are queued and checked by a monitor.
module tb_irq_coalescer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  event_in = '0;
    logic [2:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [7:0]  irq;

    irq_coalescer #(.N_SRC(8), .CNT_W(8), .TMR_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .event_in      (event_in),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  irq;
        bit          rdv;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;

    // Reference model: counters as integers, timeouts as absolute
    // deadline cycle numbers rather than down-counters.
    logic [7:0] m_status;
    logic [7:0] m_mask;
    logic [7:0] m_defer;
    int         m_thr;
    int         m_to;
    int         m_cnt [8];
    longint     m_dead [8];
    longint     now = 0;

    function automatic void model_reset();
        m_status = '0;
        m_mask   = '0;
        m_defer  = '0;
        m_thr    = 1;
        m_to     = 0;
        for (int i = 0; i < 8; i++) begin
            m_cnt[i]  = 0;
            m_dead[i] = -1;
        end
    endfunction

    function automatic logic [31:0] model_read(logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v = {24'h0, m_status};
            3'd1: v = {24'h0, m_mask};
            3'd3: v = 32'(m_thr);
            3'd4: v = 32'(m_to);
            3'd5: for (int i = 0; i < 4; i++) v = v | (32'(m_cnt[i]) << (8 * i));
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void model_cycle(logic [7:0] ev, bit r, bit w,
                                        logic [2:0] a, logic [31:0] d);
        exp_t e;
        logic [7:0] fire, setr, clr;
        int thr, c, nc;
        bit tmo;
        e.irq = m_status & m_mask;
        e.rdv = r;
        e.rd  = model_read(a);
        thr = (m_thr == 0) ? 1 : m_thr;
        fire = '0;
        for (int i = 0; i < 8; i++) begin
            c  = m_cnt[i];
            nc = ev[i] ? ((c < 255) ? c + 1 : c) : c;
            tmo = (c > 0) && (m_to != 0) && (m_dead[i] == now);
            fire[i] = (nc >= thr) || tmo;
            if (ev[i] && c == 0) m_dead[i] = (m_to != 0) ? now + m_to : -1;
            if (fire[i]) begin
                m_cnt[i]  = 0;
                m_dead[i] = -1;
            end else begin
                m_cnt[i] = nc;
            end
        end
        setr = fire | m_defer | ((w && a == 3'd2) ? d[7:0] : 8'h00);
        clr  = (w && a == 3'd0) ? d[7:0] : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (clr[i]) begin
                m_status[i] = 1'b0;
                m_defer[i]  = setr[i];
            end else begin
                if (setr[i]) m_status[i] = 1'b1;
                m_defer[i] = 1'b0;
            end
        end
        if (w && a == 3'd1) m_mask = d[7:0];
        if (w && a == 3'd3) m_thr  = int'(d[7:0]);
        if (w && a == 3'd4) m_to   = int'(d[15:0]);
        now++;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            checks++;
            if (irq !== me.irq) begin
                errors++;
                $display("FAIL irq t=%0t actual=%h required=%h", $time, irq, me.irq);
            end
            if (me.rdv) begin
                checks++;
                if (csr_readdata !== me.rd) begin
                    errors++;
                    $display("FAIL readdata t=%0t actual=%h required=%h",
                             $time, csr_readdata, me.rd);
                end
            end
        end
    end

    task automatic step(input logic [7:0] ev, input bit r, input bit w,
                        input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        event_in      = ev;
        csr_read      = r;
        csr_write     = w;
        csr_address   = a;
        csr_writedata = d;
        model_cycle(ev, r, w, a, d);
        @(posedge clk);
        #2;
        event_in  = '0;
        csr_read  = 1'b0;
        csr_write = 1'b0;
    endtask

    task automatic cyc(input logic [7:0] ev);
        step(ev, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(8'h00, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(8'h00, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        event_in  = '0;
        csr_read  = 1'b0;
        csr_write = 1'b0;
        #1;
        chk("reset_irq", 32'(irq), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int rise;
    logic [2:0]  ra;
    logic [31:0] rdat;
    int op;

    initial begin
        model_reset();
        apply_reset();
        for (int a = 0; a < 8; a++) rd(3'(a));

        // Single event, threshold 1, then W1C.
        wr(3'd1, 32'hFF);
        wr(3'd3, 32'h1);
        cyc(8'h08);
        cyc(8'h00);
        chk("t1_irq", 32'(irq), 32'h08);
        rd(3'd0);
        chk("t1_status", csr_readdata, 32'h08);
        wr(3'd0, 32'h08);
        cyc(8'h00);
        cyc(8'h00);
        chk("t1_clear", 32'(irq), 32'h0);

        // Count threshold of 4.
        wr(3'd3, 32'h4);
        wr(3'd4, 32'h0);
        wr(3'd1, 32'h01);
        for (int k = 0; k < 3; k++) begin
            cyc(8'h01);
            cyc(8'h00);
        end
        rd(3'd5);
        chk("t2_count3", csr_readdata & 32'hFF, 32'h3);
        cyc(8'h01);
        cyc(8'h00);
        rd(3'd5);
        chk("t2_irq", 32'(irq), 32'h01);
        chk("t2_count0", csr_readdata & 32'hFF, 32'h0);
        wr(3'd0, 32'hFF);

        // Timeout path: one event, threshold never reached.
        wr(3'd3, 32'd10);
        wr(3'd4, 32'd20);
        wr(3'd1, 32'hFF);
        cyc(8'h00);
        cyc(8'h00);
        cyc(8'h20);
        rise = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(8'h00);
            if (rise < 0 && irq[5]) rise = k + 1;
        end
        chk("t3_rise", 32'(rise), 32'd22);
        wr(3'd0, 32'hFF);
        wr(3'd4, 32'h0);

        // W1C colliding with a fire: forced low-time of one cycle.
        wr(3'd3, 32'h1);
        wr(3'd2, 32'h04);
        cyc(8'h00);
        chk("t4_pre", 32'(irq[2]), 32'h1);
        step(8'h04, 1'b0, 1'b1, 3'd0, 32'h04);
        chk("t4_c0", 32'(irq[2]), 32'h1);
        rd(3'd0);
        chk("t4_low", 32'(irq[2]), 32'h0);
        chk("t4_st0", csr_readdata & 32'h4, 32'h0);
        rd(3'd0);
        chk("t4_high", 32'(irq[2]), 32'h1);
        chk("t4_st1", csr_readdata & 32'h4, 32'h4);
        wr(3'd0, 32'hFF);

        // FORCE with mask off, then mask-driven re-delivery.
        wr(3'd1, 32'h00);
        wr(3'd2, 32'h81);
        cyc(8'h00);
        rd(3'd0);
        chk("t5_status", csr_readdata, 32'h81);
        chk("t5_masked", 32'(irq), 32'h0);
        wr(3'd1, 32'h80);
        cyc(8'h00);
        chk("t5_irq", 32'(irq), 32'h80);
        wr(3'd1, 32'h00);
        cyc(8'h00);
        chk("t5_drop", 32'(irq), 32'h0);
        wr(3'd1, 32'h80);
        cyc(8'h00);
        chk("t5_reedge", 32'(irq), 32'h80);
        step(8'h00, 1'b1, 1'b1, 3'd1, 32'h3C);
        chk("t5_rdwr", csr_readdata, 32'h80);
        wr(3'd0, 32'hFF);

        // Saturating-range threshold: fire at exactly 255 events.
        wr(3'd1, 32'h00);
        wr(3'd3, 32'hFF);
        for (int k = 0; k < 254; k++) cyc(8'h02);
        rd(3'd5);
        chk("t6_cnt254", (csr_readdata >> 8) & 32'hFF, 32'd254);
        rd(3'd0);
        chk("t6_nofire", csr_readdata & 32'h2, 32'h0);
        cyc(8'h02);
        rd(3'd0);
        chk("t6_fire", csr_readdata & 32'h2, 32'h2);

        // Reset in the middle of accumulation with irq asserted.
        wr(3'd3, 32'd200);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'h10);
        for (int k = 0; k < 50; k++) cyc(8'h02);
        apply_reset();
        rd(3'd0);
        chk("t6_rst_status", csr_readdata, 32'h0);
        rd(3'd5);
        chk("t6_rst_count", csr_readdata, 32'h0);
        for (int a = 1; a < 5; a++) rd(3'(a));

        // Random traffic.
        wr(3'd1, 32'hFF);
        for (int k = 0; k < 1500; k++) begin
            op = $urandom_range(0, 5);
            ra = 3'($urandom_range(0, 7));
            case (ra)
                3'd3:    rdat = 32'($urandom_range(0, 6));
                3'd4:    rdat = 32'($urandom_range(0, 15));
                3'd2:    rdat = $urandom & $urandom;
                default: rdat = $urandom;
            endcase
            step(8'($urandom & $urandom), op == 1 || op == 3,
                 op == 2 || op == 3, ra, rdat);
        end

        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
